product_bcd_conv: RTL and testbench

Downstream consumer of the Booth multiplier (boothMult) result. On each new multiplier result, it captures the signed 16-bit product carried in Product[16:1] and converts it to sign-magnitude form. The magnitude is converted to 5 BCD digits with a sequential shift-add-3 (double-dabble) engine. Its outputs drive the board's seven-segment display path.

---
 rtl/mult_pkg.sv | 19 +
 rtl/bcd_digit_adj.sv | 22 ++
 rtl/product_bcd_conv.sv | 122 ++++++++++++
 tb/tb_product_bcd_conv.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the Booth multiplier result path.
// Holds the bus widths, the BCD converter state encoding and the
// BCD digit type used by product_bcd_conv and bcd_digit_adj.
package mult_pkg;

  localparam int unsigned PROD_W = 18;
  localparam int unsigned VAL_W  = 16;
  localparam int unsigned DIGITS = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_digit_adj.sv
`timescale 1ns/1ps
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more
// so that the following left shift carries correctly into the next digit.
// Ports:
//   din  - current BCD digit
//   dout - corrected digit (din >= 5 ? din + 3 : din)
module bcd_digit_adj
  import mult_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  bcd_digit_t d;

  always_comb begin
    d = din;
    if (din >= 4'd5) d = din + 4'd3;
    dout = d;
  end

endmodule

// File: rtl/product_bcd_conv.sv
`timescale 1ns/1ps
// Converts the signed Booth multiplier result Product[VAL_W:1] into
// sign-magnitude BCD for the seven-segment display path. A rising edge
// on Finish (while idle) captures the product; a shift-add-3 engine then
// runs VAL_W iterations and publishes Sign/BCD with a one-cycle Valid.
// Ports:
//   clk     - system clock, rising edge
//   Resetn  - asynchronous active-low reset
//   Finish  - multiplier done level; rising edge starts a conversion
//   Product - multiplier result bus (bits 0 and PROD_W-1 ignored)
//   Busy    - conversion in progress
//   Valid   - one-cycle pulse when Sign/BCD are updated
//   Sign    - result negative (never set for zero)
//   BCD     - magnitude digits, BCD[3:0] = ones
module product_bcd_conv #(
  parameter int unsigned PROD_W = 18,
  parameter int unsigned VAL_W  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  Resetn,
  input  logic                  Finish,
  input  logic [PROD_W-1:0]     Product,
  output logic                  Busy,
  output logic                  Valid,
  output logic                  Sign,
  output logic [4*DIGITS-1:0]   BCD
);

  import mult_pkg::state_t;
  import mult_pkg::IDLE;
  import mult_pkg::SHIFT;
  import mult_pkg::DONE;

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + VAL_W;
  localparam int unsigned CNT_W = $clog2(VAL_W) + 1;

  state_t             state, state_nx;
  logic               finish_d;
  logic [CNT_W-1:0]   cnt;
  logic [SR_W-1:0]    sr;
  logic               sign_r;
  logic               nz_r;
  logic [VAL_W-1:0]   val;
  logic [VAL_W-1:0]   mag;
  logic [BCD_W-1:0]   adj;
  logic [SR_W-1:0]    sr_shift;
  logic               trigger;

  assign val = Product[VAL_W:1];
  // Two's-complement negate in VAL_W bits: the most negative value maps
  // onto its own bit pattern, which read unsigned is the correct magnitude.
  assign mag = val[VAL_W-1] ? -val : val;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (sr[VAL_W + 4*i +: 4]),
      .dout (adj[4*i +: 4])
    );
  end

  assign sr_shift = {adj[BCD_W-2:0], sr[VAL_W-1:0], 1'b0};

  always_comb begin
    state_nx = state;
    trigger  = Finish & ~finish_d & (state == IDLE);
    case (state)
      IDLE:    if (trigger) state_nx = SHIFT;
      SHIFT:   if (cnt == CNT_W'(VAL_W - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      finish_d <= 1'b0;
      cnt      <= '0;
      sr       <= '0;
      sign_r   <= 1'b0;
      nz_r     <= 1'b0;
      Busy     <= 1'b0;
      Valid    <= 1'b0;
      Sign     <= 1'b0;
      BCD      <= '0;
    end else begin
      finish_d <= Finish;
      Valid    <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            sr     <= {{BCD_W{1'b0}}, mag};
            cnt    <= '0;
            sign_r <= val[VAL_W-1];
            // Magnitude is shifted out during conversion, so remember
            // non-zero-ness now to suppress a negative zero later.
            nz_r   <= |mag;
            Busy   <= 1'b1;
          end
        end
        SHIFT: begin
          sr  <= sr_shift;
          cnt <= cnt + CNT_W'(1);
        end
        DONE: begin
          BCD   <= sr[SR_W-1:VAL_W];
          Sign  <= sign_r & nz_r;
          Valid <= 1'b1;
          Busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_conv.sv
`timescale 1ns/1ps
module tb_product_bcd_conv;

  logic        clk = 1'b0;
  logic        Resetn;
  logic        Finish;
  logic [17:0] Product;
  logic        Busy, Valid, Sign;
  logic [19:0] BCD;

  always #5 clk = ~clk;

  product_bcd_conv #(.PROD_W(18), .VAL_W(16), .DIGITS(5)) dut (
    .clk     (clk),
    .Resetn  (Resetn),
    .Finish  (Finish),
    .Product (Product),
    .Busy    (Busy),
    .Valid   (Valid),
    .Sign    (Sign),
    .BCD     (BCD)
  );

  typedef struct {
    logic [15:0] val;
    logic [19:0] bcd;
    logic        sign;
  } vec_t;

  typedef struct {
    logic [19:0] bcd;
    logic        sign;
  } exp_t;

  exp_t sb[$];
  int   errors  = 0;
  int   checks  = 0;
  int   n_valid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] v);
    exp_t e;
    int   m;
    m = v[15] ? (65536 - int'(v)) : int'(v);
    e.sign = (m != 0) && v[15];
    e.bcd  = '0;
    for (int d = 0; d < 5; d++) begin
      e.bcd[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return e;
  endfunction

  task automatic run_conv(input logic [15:0] v, input exp_t e, input string tag);
    int k;
    @(posedge clk); #1;
    Product = {1'($urandom), v, 1'($urandom)};
    Finish  = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    chk({tag, " busy_start"}, 32'(Busy), 32'd1);
    k = 0;
    while (!Valid && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, " latency"}, 32'(k), 32'd17);
    Finish = 1'b0;
    @(posedge clk); #1;
    chk({tag, " valid_clear"}, 32'(Valid), 32'd0);
    chk({tag, " busy_end"}, 32'(Busy), 32'd0);
  endtask

  vec_t tbl[9];

  initial begin
    int   nv0;
    exp_t e;
    logic [15:0] r;

    tbl[0] = '{16'h3F01, 20'h16129, 1'b0};
    tbl[1] = '{16'h4000, 20'h16384, 1'b0};
    tbl[2] = '{16'hC080, 20'h16256, 1'b1};
    tbl[3] = '{16'h0000, 20'h00000, 1'b0};
    tbl[4] = '{16'hFFFF, 20'h00001, 1'b1};
    tbl[5] = '{16'h8000, 20'h32768, 1'b1};
    tbl[6] = '{16'h7FFF, 20'h32767, 1'b0};
    tbl[7] = '{16'h270F, 20'h09999, 1'b0};
    tbl[8] = '{16'hFC18, 20'h01000, 1'b1};

    // Asynchronous reset with arbitrary inputs.
    Resetn  = 1'b1;
    Finish  = 1'b1;
    Product = 18'h2A5C3;
    #2 Resetn = 1'b0;
    #1;
    chk("rst busy",  32'(Busy),  32'd0);
    chk("rst valid", 32'(Valid), 32'd0);
    chk("rst sign",  32'(Sign),  32'd0);
    chk("rst bcd",   32'(BCD),   32'd0);
    Finish = 1'b0;
    repeat (3) @(posedge clk);
    #1 Resetn = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (Resetn && Valid === 1'b1) begin
          n_valid++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got Valid=1 expected no pending result");
          end else begin
            e = sb.pop_front();
            chk("sb sign", 32'(Sign), 32'(e.sign));
            chk("sb bcd",  32'(BCD),  32'(e.bcd));
          end
        end
      end
    join_none

    for (int i = 0; i < 9; i++) begin
      e.bcd  = tbl[i].bcd;
      e.sign = tbl[i].sign;
      run_conv(tbl[i].val, e, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      r = 16'($urandom);
      run_conv(r, model(r), $sformatf("rnd%0d", i));
    end

    // Finish held high: one conversion only.
    nv0 = n_valid;
    @(posedge clk); #1;
    Product = {2'b00, 16'h3F01, 1'b0} >> 0;
    Product = {1'b0, 16'h3F01, 1'b0};
    Finish  = 1'b1;
    e.bcd = 20'h16129; e.sign = 1'b0;
    sb.push_back(e);
    repeat (40) @(posedge clk);
    #1;
    chk("hold one_valid", 32'(n_valid - nv0), 32'd1);
    Finish = 1'b0;
    @(posedge clk); #1;

    // Finish re-toggled mid-conversion is ignored; old result held.
    nv0 = n_valid;
    Product = {1'b1, 16'h1234, 1'b1};
    Finish  = 1'b1;
    e.bcd = 20'h04660; e.sign = 1'b0;
    sb.push_back(e);
    repeat (5) @(posedge clk);
    #1 Finish = 1'b0;
    Product = {1'b0, 16'h8000, 1'b0};
    @(posedge clk); #1;
    Finish = 1'b1;
    chk("toggle bcd_hold",  32'(BCD),  32'h16129);
    chk("toggle sign_hold", 32'(Sign), 32'd0);
    chk("toggle busy",      32'(Busy), 32'd1);
    repeat (25) @(posedge clk);
    #1;
    chk("toggle one_valid", 32'(n_valid - nv0), 32'd1);
    Finish = 1'b0;
    @(posedge clk); #1;

    // Reset mid-conversion aborts without a Valid.
    nv0 = n_valid;
    Product = {1'b0, 16'hC080, 1'b0};
    Finish  = 1'b1;
    repeat (8) @(posedge clk);
    #1 Resetn = 1'b0;
    #1;
    chk("abort busy",  32'(Busy),  32'd0);
    chk("abort valid", 32'(Valid), 32'd0);
    chk("abort bcd",   32'(BCD),   32'd0);
    chk("abort sign",  32'(Sign),  32'd0);
    Finish = 1'b0;
    repeat (3) @(posedge clk);
    #1 Resetn = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("abort no_valid", 32'(n_valid - nv0), 32'd0);
    e.bcd = 20'h00007; e.sign = 1'b0;
    run_conv(16'h0007, e, "post_abort");

    repeat (3) @(posedge clk);
    #1;
    chk("sb drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
